// File: rtl/p2n_pkg.sv
// rtl/p2n_pkg.sv - shared opcodes, body lengths and state codes for the p2n response merge
package p2n_pkg;

  typedef enum logic [2:0] {
    RD_RSP  = 3'b011,
    WR_RSP  = 3'b100,
    MSG_RSP = 3'b101
  } rsp_op_e;

  localparam logic [8:0] WR_BODY  = 9'd4;
  localparam logic [8:0] MSG_BODY = 9'd5;
  localparam logic [8:0] RD_FIXED = 9'd2;

  localparam logic [7:0] NOC_IDLE_DATA = 8'h00;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BODY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  function automatic logic op_known(input logic [2:0] op);
    return (op == RD_RSP) || (op == WR_RSP) || (op == MSG_RSP);
  endfunction

  // Initial body count loaded with the header; RD_RSP is reloaded once L arrives
  function automatic logic [8:0] body_len(input logic [2:0] op);
    case (op)
      RD_RSP:  body_len = RD_FIXED;
      WR_RSP:  body_len = WR_BODY;
      MSG_RSP: body_len = MSG_BODY;
      default: body_len = 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin picker: first requester at or after the pointer
module rr_pick #(
  parameter int NPORT = 4,
  parameter int PW    = 2
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [NPORT-1:0] grant
);

  logic [PW-1:0] idx;
  logic          found;

  // Scan from the pointer with wrap-around and keep only the first hit
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NPORT; i++) begin
      idx = PW'((int'(ptr) + i) % NPORT);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/p2n_rsp_merge.sv
// rtl/p2n_rsp_merge.sv - packet-atomic round-robin merge of the p2n FIFOs onto noc_from_dev
module p2n_rsp_merge
  import p2n_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int GAP   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NPORT-1:0]   fifo_empty,
  input  logic [9*NPORT-1:0] fifo_data,
  output logic [NPORT-1:0]   fifo_rd_en,
  output logic               noc_from_dev_ctl,
  output logic [7:0]         noc_from_dev_data,
  output logic               busy,
  output logic               err_opcode,
  output logic               err_underrun
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [1:0]       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [8:0]       cnt;
  logic [1:0]       rd_stage;   // 2: ID byte next, 1: L byte next, 0: plain body
  logic [1:0]       gap_cnt;

  logic [8:0]       head [NPORT];
  logic [NPORT-1:0] grant;
  logic [NPORT-1:0] rd_sel;
  logic [PW-1:0]    gidx;
  logic [PW-1:0]    sel_idx;
  logic [8:0]       word;
  logic             pop;
  logic             hdr_ok;
  logic             filler;
  logic [8:0]       cnt_eff;
  logic             last_pop;

  rr_pick #(
    .NPORT (NPORT),
    .PW    (PW)
  ) u_rr_pick (
    .req   (~fifo_empty),
    .ptr   (ptr),
    .grant (grant)
  );

  // Word selection, pop decision and end-of-packet detection
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      head[i] = fifo_data[9*i +: 9];
    end
    gidx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
    sel_idx = (state == S_BODY) ? owner : gidx;
    word    = head[sel_idx];
    pop     = 1'b0;
    rd_sel  = '0;
    case (state)
      S_IDLE: begin
        pop    = |grant;
        rd_sel = grant;
      end
      S_BODY: begin
        pop = !fifo_empty[owner];
        if (pop) rd_sel[owner] = 1'b1;
      end
      default: ;
    endcase
    filler  = word[8] && (word[7:0] == NOC_IDLE_DATA);
    hdr_ok  = word[8] && !filler && op_known(word[2:0]);
    // The L byte carries its own count: L remaining words plus itself
    cnt_eff = (rd_stage == 2'd1) ? ({1'b0, word[7:0]} + 9'd1) : cnt;
    last_pop = (state == S_BODY) && pop && (rd_stage != 2'd2) && (cnt_eff == 9'd1);
    fifo_rd_en = rst ? rd_sel : '0;
  end

  // Packet framing FSM with registered NOC outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= S_IDLE;
      ptr               <= '0;
      owner             <= '0;
      cnt               <= '0;
      rd_stage          <= 2'd0;
      gap_cnt           <= 2'd0;
      noc_from_dev_ctl  <= 1'b1;
      noc_from_dev_data <= NOC_IDLE_DATA;
      busy              <= 1'b0;
      err_opcode        <= 1'b0;
      err_underrun      <= 1'b0;
    end else begin
      err_opcode   <= 1'b0;
      err_underrun <= 1'b0;
      case (state)
        S_IDLE: begin
          noc_from_dev_ctl  <= 1'b1;
          noc_from_dev_data <= NOC_IDLE_DATA;
          busy              <= 1'b0;
          if (pop) begin
            if (hdr_ok) begin
              noc_from_dev_data <= word[7:0];
              busy              <= 1'b1;
              owner             <= gidx;
              cnt               <= body_len(word[2:0]);
              rd_stage          <= (word[2:0] == RD_RSP) ? 2'd2 : 2'd0;
              state             <= S_BODY;
            end else if (!filler) begin
              err_opcode <= 1'b1;
            end
          end
        end
        S_BODY: begin
          busy             <= 1'b1;
          noc_from_dev_ctl <= 1'b0;
          if (pop) begin
            noc_from_dev_data <= word[7:0];
            err_opcode        <= word[8];
            cnt               <= cnt_eff - 9'd1;
            if (rd_stage != 2'd0) rd_stage <= rd_stage - 2'd1;
            if (last_pop) begin
              ptr <= (int'(owner) == NPORT - 1) ? '0 : owner + 1'b1;
              if (GAP > 0) begin
                state   <= S_GAP;
                gap_cnt <= 2'(GAP - 1);
              end else begin
                state <= S_IDLE;
              end
            end
          end else begin
            noc_from_dev_data <= NOC_IDLE_DATA;
            err_underrun      <= 1'b1;
          end
        end
        S_GAP: begin
          noc_from_dev_ctl  <= 1'b1;
          noc_from_dev_data <= NOC_IDLE_DATA;
          busy              <= 1'b0;
          if (gap_cnt == 2'd0) state <= S_IDLE;
          else gap_cnt <= gap_cnt - 2'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p2n_rsp_merge.sv
// tb/tb_p2n_rsp_merge.sv - randomized and directed self-checking bench for p2n_rsp_merge
module tb_p2n_rsp_merge;

  localparam int NP  = 4;
  localparam int GAP = 1;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     fifo_empty;
  logic [9*NP-1:0]   fifo_data;
  logic [NP-1:0]     fifo_rd_en;
  logic [NP-1:0]     pend;
  logic              noc_from_dev_ctl;
  logic [7:0]        noc_from_dev_data;
  logic              busy;
  logic              err_opcode;
  logic              err_underrun;

  logic [8:0]        q [NP][$];
  logic [8:0]        exp_w [$];
  int                exp_errs;
  int                mptr;
  logic [8:0]        tr_w [$];
  logic [NP-1:0]     tr_rd [$];
  logic              tr_busy [$];
  logic              tr_eo [$];
  logic              tr_eu [$];
  int                n_chk = 0;
  int                n_err = 0;

  p2n_rsp_merge #(
    .NPORT (NP),
    .GAP   (GAP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_empty        (fifo_empty),
    .fifo_data         (fifo_data),
    .fifo_rd_en        (fifo_rd_en),
    .noc_from_dev_ctl  (noc_from_dev_ctl),
    .noc_from_dev_data (noc_from_dev_data),
    .busy              (busy),
    .err_opcode        (err_opcode),
    .err_underrun      (err_underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) pend <= fifo_rd_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      fifo_empty[i]       = (q[i].size() == 0);
      fifo_data[9*i +: 9] = (q[i].size() == 0) ? 9'h1AA : q[i][0];
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      if (pend[i]) begin
        chk("pop_nonempty", 32'(q[i].size() != 0), 32'd1);
        if (q[i].size() != 0) void'(q[i].pop_front());
      end
    end
    drive();
    #1;
  endtask

  task automatic push_pkt(input int p, input logic [7:0] hdr, input int l, input logic [7:0] base);
    int n;
    q[p].push_back({1'b1, hdr});
    n = 0;
    case (hdr[2:0])
      3'b011: begin
        q[p].push_back({1'b0, base});
        q[p].push_back({1'b0, 8'(l)});
        n = l;
      end
      3'b100: n = 4;
      3'b101: n = 5;
      default: n = 0;
    endcase
    for (int k = 0; k < n; k++) q[p].push_back({1'b0, base + 8'(k) + 8'd1});
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NP; i++) if (q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Packet-level reference: walk the preloaded queues in round-robin packet order
  task automatic build_exp();
    logic [8:0] m [NP][$];
    logic [8:0] w;
    logic [8:0] b;
    int p;
    int n;
    bit any;
    exp_w.delete();
    exp_errs = 0;
    for (int i = 0; i < NP; i++) m[i] = q[i];
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      p = 0;
      for (int k = 0; k < NP; k++) begin
        if (!any && m[(mptr + k) % NP].size() != 0) begin
          p   = (mptr + k) % NP;
          any = 1'b1;
        end
      end
      if (any) begin
        w = m[p].pop_front();
        if (!(w[8] && w[7:0] == 8'h00)) begin
          if (!w[8] || !(w[2:0] inside {3'b011, 3'b100, 3'b101})) begin
            exp_errs++;
          end else begin
            exp_w.push_back(w);
            if (w[2:0] == 3'b100) n = 4;
            else if (w[2:0] == 3'b101) n = 5;
            else begin
              b = m[p][1];
              n = 2 + int'(b[7:0]);
            end
            for (int k = 0; k < n; k++) begin
              b = m[p].pop_front();
              exp_w.push_back({1'b0, b[7:0]});
            end
            mptr = (p + 1) % NP;
          end
        end
      end
    end
  endtask

  task automatic run(input int maxc);
    int tail;
    bit done;
    tr_w.delete(); tr_rd.delete(); tr_busy.delete(); tr_eo.delete(); tr_eu.delete();
    tail = 0;
    done = 1'b0;
    for (int c = 0; c < maxc && !done; c++) begin
      tr_w.push_back({noc_from_dev_ctl, noc_from_dev_data});
      tr_rd.push_back(fifo_rd_en);
      tr_busy.push_back(busy);
      tr_eo.push_back(err_opcode);
      tr_eu.push_back(err_underrun);
      if (all_empty() && !busy) tail++;
      else tail = 0;
      if (tail >= GAP + 3) done = 1'b1;
      else step();
    end
    chk("run_completes", 32'(done), 32'd1);
  endtask

  function automatic logic [8:0] trw(input int t);
    if (t < 0 || t >= tr_w.size()) return 9'h1FF;
    return tr_w[t];
  endfunction

  function automatic int find_hdr(input int from);
    int r;
    r = -1;
    for (int t = (from < 0 ? 0 : from); t < tr_w.size(); t++) begin
      if (r < 0 && tr_w[t][8] && tr_w[t][7:0] != 8'h00) r = t;
    end
    return r;
  endfunction

  task automatic compare(input string tag);
    logic [8:0] got [$];
    int nbad;
    int nbusy;
    int neo;
    int neu;
    nbad = 0; nbusy = 0; neo = 0; neu = 0;
    foreach (tr_w[t]) if (tr_w[t] != 9'h100) got.push_back(tr_w[t]);
    foreach (exp_w[i]) if (i >= got.size() || got[i] !== exp_w[i]) nbad++;
    foreach (tr_busy[t]) begin
      if (tr_busy[t]) nbusy++;
      if (tr_eo[t]) neo++;
      if (tr_eu[t]) neu++;
    end
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_w.size()));
    chk({tag, "_bad_words"}, 32'(nbad), 32'd0);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_w.size()));
    chk({tag, "_err_opcode"}, 32'(neo), 32'(exp_errs));
    chk({tag, "_err_underrun"}, 32'(neu), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < NP; i++) q[i].delete();
    drive();
    mptr = 0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  initial begin
    int h, h0, h1, h2, n, n0100, nany;
    bit found;
    logic [2:0] bad_ops [5];
    logic [2:0] op;
    bad_ops = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd7};

    rst  = 1'b0;
    mptr = 0;
    pend = '0;
    drive();
    step();
    step();
    chk("rst_out", 32'({noc_from_dev_ctl, noc_from_dev_data}), 32'h100);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_err_opcode", 32'(err_opcode), 32'd0);
    chk("rst_err_underrun", 32'(err_underrun), 32'd0);
    rst = 1'b1;
    step();

    // Single WR_RSP on port 2
    push_pkt(2, 8'h04, 0, 8'hB0);
    settle();
    build_exp();
    run(200);
    compare("wr_p2");
    n0100 = 0; nany = 0;
    foreach (tr_rd[t]) begin
      if (tr_rd[t] == 4'b0100) n0100++;
      if (tr_rd[t] != 4'b0000) nany++;
    end
    chk("wr_rd_en_0100_cycles", 32'(n0100), 32'd5);
    chk("wr_rd_en_total", 32'(nany), 32'd5);
    h = find_hdr(0);
    chk("wr_hdr", 32'(trw(h)), 32'h104);
    for (int k = 1; k <= 4; k++) chk("wr_body", 32'(trw(h + k)), 32'({1'b0, 8'hB0 + 8'(k)}));
    chk("wr_idle_after", 32'(trw(h + 5)), 32'h100);

    // MSG on ports 0 and 3 from pointer 0, then check the pointer wrapped to 0
    do_reset();
    push_pkt(0, 8'h05, 0, 8'hA0);
    push_pkt(3, 8'h05, 0, 8'hC0);
    settle();
    build_exp();
    run(200);
    compare("msg_p0_p3");
    h0 = find_hdr(0);
    h1 = find_hdr(h0 + 1);
    chk("msg_first_from_p0", 32'(trw(h0 + 1)), 32'h0A1);
    chk("msg_spacing", 32'(h1 - h0), 32'(6 + GAP));

    push_pkt(0, 8'h04, 0, 8'h10);
    push_pkt(1, 8'h03, 3, 8'h20);
    push_pkt(2, 8'h05, 0, 8'h30);
    settle();
    build_exp();
    run(200);
    compare("mix");
    h0 = find_hdr(0);
    h1 = find_hdr(h0 + 1);
    h2 = find_hdr(h1 + 1);
    chk("mix_wrap_to_p0", 32'(trw(h0 + 1)), 32'h011);
    chk("mix_wr_spacing", 32'(h1 - h0), 32'(5 + GAP));
    chk("rd_l3_hdr", 32'(trw(h1)), 32'h103);
    chk("rd_l3_len_byte", 32'(trw(h1 + 2)), 32'h003);
    chk("rd_l3_spacing", 32'(h2 - h1), 32'(6 + GAP));

    // RD_RSP with L=255 must not truncate
    push_pkt(0, 8'h03, 255, 8'h40);
    settle();
    build_exp();
    run(1000);
    compare("rd_l255");
    h = find_hdr(0);
    n = 0;
    for (int t = h; t >= 0 && t < tr_w.size(); t++) begin
      if (tr_w[t] == 9'h100) break;
      n++;
    end
    chk("rd_l255_contig", 32'(n), 32'd258);

    // Unknown opcode is dropped, the following packet is forwarded
    q[1].push_back(9'h107);
    push_pkt(1, 8'h04, 0, 8'h50);
    settle();
    build_exp();
    run(200);
    compare("badop");
    chk("badop_first_out", 32'(trw(find_hdr(0))), 32'h104);

    // Reset mid-packet
    do_reset();
    push_pkt(2, 8'h04, 0, 8'h20);
    settle();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if ({noc_from_dev_ctl, noc_from_dev_data} == 9'h022) found = 1'b1;
    end
    chk("rst_mid_reached_body2", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_out", 32'({noc_from_dev_ctl, noc_from_dev_data}), 32'h100);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rd_en", 32'(fifo_rd_en), 32'd0);
    step();
    step();
    for (int i = 0; i < NP; i++) q[i].delete();
    drive();
    mptr = 0;
    rst = 1'b1;
    step();
    push_pkt(2, 8'h04, 0, 8'h60);
    settle();
    build_exp();
    run(200);
    compare("post_rst");
    h = find_hdr(0);
    chk("post_rst_hdr", 32'(trw(h)), 32'h104);
    chk("post_rst_body1", 32'(trw(h + 1)), 32'h061);

    // Randomized multi-port traffic with fillers and bad headers
    for (int it = 0; it < 8; it++) begin
      for (int p = 0; p < NP; p++) begin
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
          case ($urandom_range(0, 9))
            0: q[p].push_back(9'h100);
            1: q[p].push_back({1'b1, 5'($urandom_range(1, 31)), bad_ops[$urandom_range(0, 4)]});
            default: ;
          endcase
          case ($urandom_range(0, 2))
            0: op = 3'b011;
            1: op = 3'b100;
            default: op = 3'b101;
          endcase
          push_pkt(p, {5'($urandom), op}, $urandom_range(0, 12), 8'($urandom));
        end
      end
      settle();
      build_exp();
      run(3000);
      compare("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
